// File: rtl/bcd_timer_pkg.sv
// Shared definitions for the two-digit BCD countdown timer: digit width,
// state encoding and the load-value clamp helper.
package bcd_timer_pkg;

   localparam int unsigned BCD_W = 4;
   localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = ST_IDLE,
      S_RUN   = ST_RUN,
      S_PAUSE = ST_PAUSE,
      S_DONE  = ST_DONE
   } state_t;

   // Out-of-range load values saturate to 9 rather than displaying garbage.
   function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] d);
      return (d > BCD_MAX) ? BCD_MAX : d;
   endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// Single BCD digit decrementer: wraps 0 -> 9 and reports a borrow to the
// next more significant digit.
module bcd_digit_down
   import bcd_timer_pkg::*;
(
   input  logic [BCD_W-1:0] digit,
   input  logic             dec,
   output logic [BCD_W-1:0] next_digit,
   output logic             borrow
);

   // NOTE: pure combinational block; every output gets a value on every path
   // so no latch can be inferred.
   always_comb begin
      next_digit = digit;
      borrow     = 1'b0;
      if (dec) begin
         if (digit == '0) begin
            next_digit = BCD_MAX;
            borrow     = 1'b1;
         end else begin
            next_digit = digit - 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD countdown driven by a one-second strobe, with start/pause
// control and timeout flags. Optional macro: TIMER_AUTO_RELOAD_EN.
module bcd_countdown_timer
   import bcd_timer_pkg::*;
#(
   parameter logic [BCD_W-1:0] INIT_TENS = 4'd3,
   parameter logic [BCD_W-1:0] INIT_ONES = 4'd0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             tick,
   input  logic             load,
   input  logic [BCD_W-1:0] load_tens,
   input  logic [BCD_W-1:0] load_ones,
   input  logic             start,
   input  logic             pause,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones,
   output logic             running,
   output logic             timeout,
   output logic             timeout_pulse
);

   state_t           state;
   logic [BCD_W-1:0] tens_next;
   logic [BCD_W-1:0] ones_next;
   logic             ones_borrow;
   logic             tens_borrow;
   logic             dec_req;
   logic             expire;

`ifdef TIMER_AUTO_RELOAD_EN
   logic [BCD_W-1:0] shadow_tens;
   logic [BCD_W-1:0] shadow_ones;
`endif

   // A tick only counts in RUN when nothing of higher priority is asserted.
   assign dec_req = (state == S_RUN) && en && tick && !load && !pause;

   bcd_digit_down u_ones (
      .digit      (ones),
      .dec        (dec_req),
      .next_digit (ones_next),
      .borrow     (ones_borrow)
   );

   bcd_digit_down u_tens (
      .digit      (tens),
      .dec        (ones_borrow),
      .next_digit (tens_next),
      .borrow     (tens_borrow)
   );

   // A tens borrow would mean wrapping below 00; treat it as expiry as well.
   assign expire = dec_req && (((tens_next == '0) && (ones_next == '0)) || tens_borrow);

   // NOTE: all state and outputs are registered with non-blocking assignments
   // so every reader sees the pre-edge values, independent of block order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         tens          <= INIT_TENS;
         ones          <= INIT_ONES;
         running       <= 1'b0;
         timeout       <= 1'b0;
         timeout_pulse <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
         shadow_tens   <= INIT_TENS;
         shadow_ones   <= INIT_ONES;
`endif
      end else begin
         timeout_pulse <= 1'b0;
         if (load) begin
            tens        <= clamp_bcd(load_tens);
            ones        <= clamp_bcd(load_ones);
            state       <= S_IDLE;
            running     <= 1'b0;
            timeout     <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
            shadow_tens <= clamp_bcd(load_tens);
            shadow_ones <= clamp_bcd(load_ones);
`endif
         end else begin
            case (state)
               S_IDLE, S_PAUSE: begin
                  if (!pause && start) begin
                     if ((tens == '0) && (ones == '0)) begin
                        state         <= S_DONE;
                        timeout       <= 1'b1;
                        timeout_pulse <= 1'b1;
                     end else begin
                        state   <= S_RUN;
                        running <= 1'b1;
                     end
                  end
               end
               S_RUN: begin
                  if (pause) begin
                     state   <= S_PAUSE;
                     running <= 1'b0;
                  end else if (expire) begin
                     tens          <= '0;
                     ones          <= '0;
                     state         <= S_DONE;
                     running       <= 1'b0;
                     timeout       <= 1'b1;
                     timeout_pulse <= 1'b1;
                  end else if (dec_req) begin
                     tens <= tens_next;
                     ones <= ones_next;
                  end
               end
               S_DONE: begin
`ifdef TIMER_AUTO_RELOAD_EN
                  // Reload from the last loaded value; a 00 shadow stays expired.
                  if ((shadow_tens != '0) || (shadow_ones != '0)) begin
                     tens    <= shadow_tens;
                     ones    <= shadow_ones;
                     state   <= S_RUN;
                     running <= 1'b1;
                     timeout <= 1'b0;
                  end
`endif
               end
               default: begin
                  state   <= S_IDLE;
                  running <= 1'b0;
                  timeout <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Self-checking bench for bcd_countdown_timer: a table of single-cycle
// vectors plus hand-written expiry sequences (sticky or auto-reload build).
module tb_bcd_countdown_timer;

   logic       clk;
   logic       reset;
   logic       en;
   logic       tick;
   logic       load;
   logic [3:0] load_tens;
   logic [3:0] load_ones;
   logic       start;
   logic       pause;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       running;
   logic       timeout;
   logic       timeout_pulse;

   int n_checks;
   int n_errors;

   typedef struct {
      logic       reset;
      logic       en;
      logic       tick;
      logic       load;
      logic [3:0] lt;
      logic [3:0] lo;
      logic       start;
      logic       pause;
      logic [3:0] e_tens;
      logic [3:0] e_ones;
      logic       e_run;
      logic       e_to;
      logic       e_pulse;
   } vec_t;

   bcd_countdown_timer dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .tick          (tick),
      .load          (load),
      .load_tens     (load_tens),
      .load_ones     (load_ones),
      .start         (start),
      .pause         (pause),
      .tens          (tens),
      .ones          (ones),
      .running       (running),
      .timeout       (timeout),
      .timeout_pulse (timeout_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic r, input logic e, input logic t, input logic l,
                        input logic [3:0] lt, input logic [3:0] lo,
                        input logic s, input logic p);
      reset     = r;
      en        = e;
      tick      = t;
      load      = l;
      load_tens = lt;
      load_ones = lo;
      start     = s;
      pause     = p;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [3:0] et, input logic [3:0] eo,
                        input logic er, input logic eto, input logic ep);
      logic [10:0] act;
      logic [10:0] exp;
      act = {tens, ones, running, timeout, timeout_pulse};
      exp = {et, eo, er, eto, ep};
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got tens=%h ones=%h run=%b to=%b pulse=%b, want tens=%h ones=%h run=%b to=%b pulse=%b",
                  name, tens, ones, running, timeout, timeout_pulse, et, eo, er, eto, ep);
      end
   endtask

   vec_t vecs[28];

   initial begin
      n_checks = 0;
      n_errors = 0;
      drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);

      //            rst   en    tick  load  lt    lo    start pause  tens  ones  run   to    pulse
      vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h1, 4'h2, 1'b0, 1'b0, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h1, 4'h2, 1'b1, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h1, 1'b1, 1'b0, 1'b0};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 4'h9, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 4'h5, 1'b0, 1'b0, 4'h2, 4'h5, 1'b0, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h2, 4'h5, 1'b1, 1'b0, 1'b0};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h2, 4'h4, 1'b1, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h2, 4'h3, 1'b1, 1'b0, 1'b0};
      vecs[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h2, 4'h3, 1'b0, 1'b0, 1'b0};
      vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h2, 4'h3, 1'b1, 1'b0, 1'b0};
      vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h2, 4'h2, 1'b1, 1'b0, 1'b0};
      vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h2, 4'h2, 1'b1, 1'b0, 1'b0};
      vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h2, 4'h2, 1'b1, 1'b0, 1'b0};
      vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'hA, 4'h7, 1'b0, 1'b0, 4'h9, 4'h7, 1'b0, 1'b0, 1'b0};
      vecs[23] = '{1'b0, 1'b1, 1'b0, 1'b1, 4'h3, 4'hF, 1'b0, 1'b0, 4'h3, 4'h9, 1'b0, 1'b0, 1'b0};
      vecs[24] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h3, 4'h9, 1'b1, 1'b0, 1'b0};
      vecs[25] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'h1, 4'h5, 1'b0, 1'b0, 4'h1, 4'h5, 1'b0, 1'b0, 1'b0};
      vecs[26] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0, 4'h1, 4'h5, 1'b1, 1'b0, 1'b0};
      vecs[27] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 4'h3, 4'h0, 1'b0, 1'b0, 1'b0};

      for (int i = 0; i < 28; i++) begin
         drive(vecs[i].reset, vecs[i].en, vecs[i].tick, vecs[i].load, vecs[i].lt,
               vecs[i].lo, vecs[i].start, vecs[i].pause);
         check($sformatf("vec%0d", i), vecs[i].e_tens, vecs[i].e_ones,
               vecs[i].e_run, vecs[i].e_to, vecs[i].e_pulse);
      end

      // Expiry from 01: pulse on the decrementing edge.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h1, 1'b0, 1'b0);
      check("load01", 4'h0, 4'h1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
      check("start01", 4'h0, 4'h1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      check("expire01", 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
`ifdef TIMER_AUTO_RELOAD_EN
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      check("reload01", 4'h0, 4'h1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      check("expire01_again", 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);

      // load 02, two ticks to 00, reload, and a second expiry.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h2, 1'b0, 1'b0);
      check("load02", 4'h0, 4'h2, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
      check("start02", 4'h0, 4'h2, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      check("tick02_a", 4'h0, 4'h1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      check("expire02_a", 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      check("reload02", 4'h0, 4'h2, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      check("tick02_b", 4'h0, 4'h1, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      check("expire02_b", 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
`else
      // DONE is sticky: ticks and start change nothing, pulse stays low.
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, (i >= 2), 1'b0);
         check($sformatf("sticky%0d", i), 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      end
`endif

      // start on a loaded 00 goes straight to DONE; a 00 shadow never reloads.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
      check("load00", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b0);
      check("start00", 4'h0, 4'h0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      check("done00_hold", 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 1'b1, 4'h4, 4'h4, 1'b0, 1'b0);
      check("load_clears_done", 4'h4, 4'h4, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Two-digit BCD countdown stage that consumes the 1-cycle one-second strobe from the timer chain.
- Decrements 99..00 under start/pause control and raises a timeout when 00 is reached.
- Drives the game's seconds display and the round-end logic.
- Output digits feed the 7-segment decoders directly.

Parameters:
- INIT_TENS, 4'd3, tens digit after reset (BCD 0-9).
- INIT_ONES, 4'd0, ones digit after reset (BCD 0-9).

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  global enable; when low, tick is ignored.
- tick  input  1  one-cycle strobe, one per second, from the upstream timer.
- load  input  1  load load_tens/load_ones, enter IDLE.
- load_tens  input  4  BCD tens value to load.
- load_ones  input  4  BCD ones value to load.
- start  input  1  begin or resume counting.
- pause  input  1  suspend counting.
- tens  output  4  current tens digit, registered.
- ones  output  4  current ones digit, registered.
- running  output  1  high while state is RUN.
- timeout  output  1  level; high while state is DONE.
- timeout_pulse  output  1  one-cycle pulse on entry to DONE.

Behaviour:
- States: IDLE, RUN, PAUSE, DONE.
- Reset: state IDLE; tens=INIT_TENS; ones=INIT_ONES; shadow=INIT value; running=0, timeout=0, timeout_pulse=0.
- Per-cycle priority: reset > load > pause > start > tick.
- load (any state):
  - digits <= load values; shadow <= load values; state IDLE.
  - Any digit >9 is clamped to 9 in both digits and shadow.
- start:
  - From IDLE or PAUSE with value !=00: go to RUN next cycle.
  - From IDLE or PAUSE with value 00: go to DONE, with timeout_pulse next cycle.
  - Ignored in RUN and DONE.
- pause: from RUN, go to PAUSE; digits hold. Ignored elsewhere.
- RUN, tick&en=1 decrement:
  - ones!=0: ones-1.
  - ones==0: ones=9, tens-1.
  - Value is never 00 on entry to RUN, so no wrap below 00.
- Decrement that results in 00: the same edge enters DONE, timeout=1, timeout_pulse=1 for exactly one cycle.
- Latency: digits update on the clock edge after the tick cycle.
- tick or en=0 outside RUN: no effect. tick in the same cycle as pause: pause wins, no decrement.
- DONE: digits stay 00 and timeout stays high until load or reset.
- reset or load in the same cycle as a tick: the tick is discarded.
- running is high iff state==RUN. All outputs are registered, with no combinational path from inputs.

Optional Feature:
- Macro: TIMER_AUTO_RELOAD_EN.
- Defined: in the cycle after DONE entry, digits <= shadow and state returns to RUN.
  - timeout_pulse still fires once per expiry.
  - timeout is high for that single DONE cycle only.
  - If shadow==00, stay in DONE (no reload loop).
- Undefined: DONE is sticky as described above; the shadow register may be optimised away.

Decomposition:
- Shared package bcd_timer_pkg:
  - BCD_W=4.
  - BCD_MAX=4'd9.
  - State encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2, ST_DONE=2'd3.
- Sub-module bcd_digit_down, instantiated twice:
  - Inputs: digit, dec.
  - Outputs: next digit, borrow (dec & digit==0).
  - On borrow the digit wraps to 9.
  - The ones borrow drives the tens dec.

Test Plan:
- Reset with defaults → tens=3, ones=0, running=0, timeout=0. Hold 5 ticks in IDLE → unchanged.
- load 0x12, start, 3 ticks → 11, 10, 09, each updating one cycle after its tick; running=1.
- load 0x01, start, 1 tick → 00; timeout_pulse high exactly 1 cycle; timeout held; further ticks and start → no change.
- load 0x25, start, 2 ticks → 23. Then pause together with a tick → 23 held, state PAUSE. Then start, 1 tick → 22.
- load 0xA7 → 97 displayed. load 0x00 then start → DONE with timeout_pulse; en=0 with ticks in RUN → no decrement.
- With TIMER_AUTO_RELOAD_EN: load 0x02, start, 2 ticks → 00 with pulse, then 02 and running again on the next cycle; a second expiry gives a second pulse.
